// File: rtl/uncache_axi_ctrl.sv
// uncache_axi_ctrl: request-side controller for uncached data accesses.
// Takes a memory-stage SRAM-style request with cached=0, stalls the pipeline,
// and runs one single-word read or write on the simplified bridge bus.
// Optional build macro UNCACHE_WR_POSTED_EN: posted writes with a 3-bit
// outstanding-write counter that holds back reads until all writes complete.
module uncache_axi_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                sram_en,
   input  logic [DATA_W/8-1:0] sram_wen,
   input  logic [ADDR_W-1:0]   sram_addr,
   input  logic [DATA_W-1:0]   sram_wdata,
   input  logic                cached,
   output logic                stallreq,
   output logic                hit,
   output logic                refresh,
   output logic [DATA_W-1:0]   axi_rdata,
   output logic                rd_req,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic                rd_rdy,
   input  logic                ret_valid,
   input  logic [DATA_W-1:0]   ret_data,
   output logic                wr_req,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [DATA_W/8-1:0] wr_wstrb,
   output logic [DATA_W-1:0]   wr_data,
   input  logic                wr_rdy,
   input  logic                wr_ok
);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
   } state_t;

   state_t                state;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W-1:0]     rdata_q;
   logic [DATA_W/8-1:0]   wen_q;
   logic                  start;
   logic                  is_rd;
   logic                  go;

   assign start = (state == IDLE) & sram_en & ~cached;
   assign is_rd = (sram_wen == '0);

`ifdef UNCACHE_WR_POSTED_EN
   logic [2:0] pend;
   logic       pend_inc;
   logic       pend_dec;

   // Reads wait for all posted writes to drain; writes wait while the counter is full.
   assign go       = start & (is_rd ? (pend == 3'd0) : (pend != 3'd7));
   assign pend_inc = (state == WR_REQ) & wr_rdy;
   assign pend_dec = wr_ok & ((pend != 3'd0) | pend_inc);

   // Outstanding posted-write counter, saturating at 7.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pend <= 3'd0;
      end else if (pend_inc & ~pend_dec) begin
         if (pend != 3'd7) pend <= pend + 3'd1;
      end else if (pend_dec & ~pend_inc) begin
         pend <= pend - 3'd1;
      end
   end
`else
   assign go = start;
`endif

   // The request cycle itself stalls; DONE releases the pipeline. Forced low in reset.
   assign stallreq  = resetn & (start | ((state != IDLE) & (state != DONE)));
   // Read data is forwarded combinationally in the cycle it returns.
   assign refresh   = ret_valid & ((state == RD_WAIT) | ((state == RD_REQ) & rd_rdy));
   assign axi_rdata = refresh ? ret_data : rdata_q;
   assign hit       = (state == DONE);
   assign rd_req    = (state == RD_REQ);
   assign wr_req    = (state == WR_REQ);
   assign rd_addr   = addr_q;
   assign wr_addr   = addr_q;
   assign wr_wstrb  = wen_q;
   assign wr_data   = wdata_q;

   // Transaction FSM: latches the request and sequences the bus handshakes.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wen_q   <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  addr_q  <= is_rd ? {sram_addr[ADDR_W-1:2], 2'b00} : sram_addr;
                  wdata_q <= sram_wdata;
                  wen_q   <= sram_wen;
                  state   <= is_rd ? RD_REQ : WR_REQ;
               end
            end
            RD_REQ: begin
               if (rd_rdy) begin
                  if (ret_valid) begin
                     rdata_q <= ret_data;
                     state   <= DONE;
                  end else begin
                     state   <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (ret_valid) begin
                  rdata_q <= ret_data;
                  state   <= DONE;
               end
            end
            WR_REQ: begin
`ifdef UNCACHE_WR_POSTED_EN
               if (wr_rdy) state <= DONE;
`else
               if (wr_rdy) state <= WR_WAIT;
`endif
            end
            WR_WAIT: begin
               if (wr_ok) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uncache_axi_ctrl.sv
// Testbench for uncache_axi_ctrl: schedule-driven stimulus with per-cycle
// expected outputs derived from the chosen bus delays.
module tb_uncache_axi_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic        cached;
   logic        stallreq, hit, refresh;
   logic [31:0] axi_rdata;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic        rd_rdy, ret_valid;
   logic [31:0] ret_data;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [3:0]  wr_wstrb;
   logic [31:0] wr_data;
   logic        wr_rdy, wr_ok;

   uncache_axi_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn), .sram_en(sram_en), .sram_wen(sram_wen),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .cached(cached),
      .stallreq(stallreq), .hit(hit), .refresh(refresh), .axi_rdata(axi_rdata),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
      .ret_data(ret_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
      .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_ok(wr_ok)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // expected outputs for the current cycle
   logic        chk_en = 1'b0;
   logic        e_stall, e_hit, e_ref, e_rd_req, e_wr_req;
   logic [31:0] e_rdata = 32'h0;
   logic [31:0] e_rd_addr, e_wr_addr, e_wdata;
   logic [3:0]  e_wstrb;

   // observation counters and last-seen bus fields
   int          n_stall = 0, n_hit = 0, n_ref = 0, n_rdhs = 0, n_rdreq = 0;
   logic [31:0] seen_rd_addr = 32'h0, seen_wr_addr = 32'h0, seen_wdata = 32'h0;
   logic [3:0]  seen_wstrb = 4'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("stallreq", 64'(stallreq), 64'(e_stall));
         check("hit", 64'(hit), 64'(e_hit));
         check("refresh", 64'(refresh), 64'(e_ref));
         check("rd_req", 64'(rd_req), 64'(e_rd_req));
         check("wr_req", 64'(wr_req), 64'(e_wr_req));
         check("axi_rdata", 64'(axi_rdata), 64'(e_rdata));
         if (e_rd_req) check("rd_addr", 64'(rd_addr), 64'(e_rd_addr));
         if (e_wr_req) begin
            check("wr_addr", 64'(wr_addr), 64'(e_wr_addr));
            check("wr_wstrb", 64'(wr_wstrb), 64'(e_wstrb));
            check("wr_data", 64'(wr_data), 64'(e_wdata));
         end
         if (stallreq) n_stall++;
         if (hit) n_hit++;
         if (refresh) n_ref++;
         if (rd_req) begin n_rdreq++; seen_rd_addr = rd_addr; end
         if (rd_req && rd_rdy) n_rdhs++;
         if (wr_req) begin seen_wr_addr = wr_addr; seen_wstrb = wr_wstrb; seen_wdata = wr_data; end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_clear();
      e_stall = 1'b0; e_hit = 1'b0; e_ref = 1'b0; e_rd_req = 1'b0; e_wr_req = 1'b0;
   endtask

   task automatic bus_quiet();
      rd_rdy = 1'b0; wr_rdy = 1'b0; ret_valid = 1'b0; wr_ok = 1'b0; ret_data = $urandom;
   endtask

   // pipeline-side inputs are don't-care while the block is busy
   task automatic junk_req();
      sram_en = 1'($urandom); cached = 1'($urandom); sram_wen = 4'($urandom);
      sram_addr = $urandom; sram_wdata = $urandom;
   endtask

   task automatic idle_cycles(input int n, input bit cached_hold);
      for (int i = 0; i < n; i++) begin
         if (cached_hold) begin
            sram_en = 1'b1; cached = 1'b1;
         end else begin
            sram_en = 1'($urandom);
            cached  = sram_en ? 1'b1 : 1'($urandom);
         end
         sram_wen = 4'($urandom); sram_addr = $urandom; sram_wdata = $urandom;
         rd_rdy = 1'($urandom); wr_rdy = 1'($urandom); ret_valid = 1'($urandom);
         ret_data = $urandom; wr_ok = 1'($urandom);
         exp_clear();
         step();
      end
   endtask

   // d1: cycles before rd_rdy; d2: cycles from acceptance to ret_valid (0 = same cycle)
   task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                          input int d1, input int d2);
      sram_en = 1'b1; cached = 1'b0; sram_wen = 4'h0; sram_addr = addr; sram_wdata = $urandom;
      bus_quiet(); exp_clear(); e_stall = 1'b1;
      step();
      for (int i = 0; i <= d1; i++) begin
         junk_req(); bus_quiet(); exp_clear();
         e_stall = 1'b1; e_rd_req = 1'b1; e_rd_addr = {addr[31:2], 2'b00};
         if (i == d1) begin
            rd_rdy = 1'b1;
            if (d2 == 0) begin ret_valid = 1'b1; ret_data = data; e_ref = 1'b1; e_rdata = data; end
         end else begin
            ret_valid = 1'($urandom);
         end
         step();
      end
      for (int i = 1; i <= d2; i++) begin
         junk_req(); bus_quiet(); exp_clear(); e_stall = 1'b1;
         wr_ok = 1'($urandom);
         if (i == d2) begin ret_valid = 1'b1; ret_data = data; e_ref = 1'b1; e_rdata = data; end
         step();
      end
      junk_req(); bus_quiet(); ret_valid = 1'($urandom); exp_clear(); e_hit = 1'b1;
      step();
   endtask

   // d1: cycles before wr_rdy; d2: cycles from acceptance to wr_ok (posted: idle cycles before drain)
   task automatic do_write(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] data,
                           input int d1, input int d2, input bit drain);
      sram_en = 1'b1; cached = 1'b0; sram_wen = wen; sram_addr = addr; sram_wdata = data;
      bus_quiet(); exp_clear(); e_stall = 1'b1;
      step();
      for (int i = 0; i <= d1; i++) begin
         junk_req(); bus_quiet(); exp_clear();
         e_stall = 1'b1; e_wr_req = 1'b1; e_wr_addr = addr; e_wstrb = wen; e_wdata = data;
         if (i == d1) wr_rdy = 1'b1;
         step();
      end
`ifdef UNCACHE_WR_POSTED_EN
      junk_req(); bus_quiet(); exp_clear(); e_hit = 1'b1;
      step();
      if (drain) begin
         for (int i = 1; i <= d2; i++) begin
            sram_en = 1'b0; cached = 1'b0; bus_quiet(); wr_ok = (i == d2); exp_clear();
            step();
         end
      end
`else
      for (int i = 1; i <= d2; i++) begin
         junk_req(); bus_quiet(); exp_clear(); e_stall = 1'b1;
         ret_valid = 1'($urandom);
         wr_ok = (i == d2) ? 1'b1 : 1'b0;
         step();
      end
      junk_req(); bus_quiet(); wr_ok = 1'($urandom); exp_clear(); e_hit = 1'b1;
      step();
      if (drain) exp_clear();
`endif
   endtask

   int s_stall, s_ref, s_hit, s_hs, s_rq;

   initial begin
      resetn = 1'b0; sram_en = 1'b1; cached = 1'b0; sram_wen = 4'h0;
      sram_addr = 32'h0; sram_wdata = 32'h0; bus_quiet();
      step(); step();
      // reset state
      check("rst_stallreq", 64'(stallreq), 64'd0);
      check("rst_outputs", 64'({hit, refresh, rd_req, wr_req}), 64'd0);
      check("rst_axi_rdata", 64'(axi_rdata), 64'd0);
      check("rst_regs", 64'(rd_addr | wr_data | 32'(wr_wstrb)), 64'd0);
      sram_en = 1'b0;
      resetn = 1'b1;
      exp_clear(); e_rdata = 32'h0; chk_en = 1'b1;
      step();

      // basic read, zero-wait bus
      s_stall = n_stall; s_ref = n_ref; s_hit = n_hit; s_rq = n_rdreq;
      do_read(32'hBFAF8004, 32'h12345678, 0, 1);
      check("rd_stall_cycles", 64'(n_stall - s_stall), 64'd3);
      check("rd_req_cycles", 64'(n_rdreq - s_rq), 64'd1);
      check("rd_refresh_cnt", 64'(n_ref - s_ref), 64'd1);
      check("rd_hit_cnt", 64'(n_hit - s_hit), 64'd1);
      check("rd_addr_lit", 64'(seen_rd_addr), 64'hBFAF8004);
      idle_cycles(1, 1'b0);
      check("rd_data_lit", 64'(axi_rdata), 64'h12345678);

      // write with delayed acceptance and response
      s_ref = n_ref; s_hit = n_hit;
      do_write(32'hBFAF8000, 4'b0011, 32'hDEADBEEF, 3, 2, 1'b1);
      check("wr_refresh_cnt", 64'(n_ref - s_ref), 64'd0);
      check("wr_hit_cnt", 64'(n_hit - s_hit), 64'd1);
      check("wr_fields_lit", {seen_wr_addr, 28'h0, seen_wstrb}, {32'hBFAF8000, 32'h3});
      check("wr_data_lit", 64'(seen_wdata), 64'hDEADBEEF);

      // cached requests are ignored
      s_stall = n_stall; s_rq = n_rdreq;
      idle_cycles(5, 1'b1);
      check("cached_no_stall", 64'(n_stall - s_stall), 64'd0);
      check("cached_no_rdreq", 64'(n_rdreq - s_rq), 64'd0);

      // back-to-back reads, unaligned address
      s_hs = n_rdhs; s_ref = n_ref;
      do_read(32'h1000_0007, 32'hA5A5_0001, 1, 2);
      do_read(32'h1000_0012, 32'hA5A5_0002, 0, 0);
      check("b2b_rd_handshakes", 64'(n_rdhs - s_hs), 64'd2);
      check("b2b_refresh_cnt", 64'(n_ref - s_ref), 64'd2);
      check("unaligned_rd_addr", 64'(seen_rd_addr), 64'h1000_0010);

`ifdef UNCACHE_WR_POSTED_EN
      // posted write, then a read held until the write completes
      s_hs = n_rdhs;
      do_write(32'hBFAF8010, 4'hF, 32'hCAFEF00D, 1, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         sram_en = 1'b1; cached = 1'b0; sram_wen = 4'h0; sram_addr = 32'hBFAF8010;
         bus_quiet(); wr_ok = (i == 3); exp_clear(); e_stall = 1'b1;
         step();
      end
      do_read(32'hBFAF8010, 32'h0BADC0DE, 0, 1);
      check("posted_rd_hs", 64'(n_rdhs - s_hs), 64'd1);
`endif

      // randomized traffic
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 2))
            0: do_read($urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            1: do_write($urandom, 4'($urandom_range(1, 15)), $urandom,
                        $urandom_range(0, 3), $urandom_range(1, 3), 1'b1);
            default: idle_cycles($urandom_range(1, 3), 1'b0);
         endcase
      end

      // asynchronous reset in RD_WAIT
      do_write(32'h0, 4'h1, 32'h0, 0, 1, 1'b1);
      sram_en = 1'b1; cached = 1'b0; sram_wen = 4'h0; sram_addr = 32'h2000_0004;
      bus_quiet(); exp_clear(); e_stall = 1'b1;
      step();
      bus_quiet(); rd_rdy = 1'b1; exp_clear(); e_stall = 1'b1; e_rd_req = 1'b1;
      e_rd_addr = 32'h2000_0004;
      step();
      chk_en = 1'b0; bus_quiet();
      #1 resetn = 1'b0;
      #1;
      check("arst_stallreq", 64'(stallreq), 64'd0);
      check("arst_outputs", 64'({hit, refresh, rd_req, wr_req}), 64'd0);
      check("arst_axi_rdata", 64'(axi_rdata), 64'd0);
      check("arst_regs", 64'(rd_addr | wr_addr | wr_data | 32'(wr_wstrb)), 64'd0);
      step();
      #2 resetn = 1'b1;
      sram_en = 1'b0; ret_valid = 1'b1; ret_data = 32'hFFFF_0000;
      exp_clear(); e_rdata = 32'h0; chk_en = 1'b1;
      step();
      ret_valid = 1'b1;
      step();
      idle_cycles(2, 1'b0);
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
